// File: rtl/stack_cmd_sequencer_if.sv
// ============================================================================
// Module  : stack_cmd_sequencer_if
// Brief   : Host command / response handshake bundle for stack_cmd_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface stack_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       cmd_sel;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/stack_cmd_sequencer.sv
// ============================================================================
// Module  : stack_cmd_sequencer
// Brief   : Turns host stack commands into push/pop strobes for two stacks,
//           tracking mirror occupancy so illegal commands never reach them.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stack_cmd_sequencer #(
    parameter  int WORDS = 16,
    localparam int CW    = $clog2(WORDS + 1)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    stack_cmd_sequencer_if.slave host,
    output logic                 stack_select,
    output logic                 push,
    output logic                 pop,
    output logic [7:0]           data_in,
    input  wire logic [7:0]      stk_data,
    output logic [CW-1:0]        count0,
    output logic [CW-1:0]        count1
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_READA = 3'd2;
    localparam logic [2:0] S_READB = 3'd3;
    localparam logic [2:0] S_PUSHA = 3'd4;
    localparam logic [2:0] S_PUSHB = 3'd5;
    localparam logic [2:0] S_RSP   = 3'd6;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_PEEK = 3'd3;
    localparam logic [2:0] OP_DUP  = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_MOVE = 3'd6;

    localparam logic [CW-1:0] c_WORDS = CW'(WORDS);
    localparam logic [CW-1:0] c_ONE   = CW'(1);
    localparam logic [CW-1:0] c_TWO   = CW'(2);

    logic [2:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic          sel_q, sel_d;
    logic          ssel_q, ssel_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    b_q, b_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;

    logic          w_ready;
    logic          w_ok;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_c;
    logic [CW-1:0] w_o;
    logic [7:0]    w_rsp_data;

    // cmd_ready is forced low while rst is high, even though state is already IDLE.
    assign w_ready = (state_q == S_IDLE) && !rst;
    assign w_push  = (state_q == S_PUSHA) || (state_q == S_PUSHB);
    assign w_pop   = (state_q == S_READB) ||
                     ((state_q == S_READA) &&
                      ((op_q == OP_POP) || (op_q == OP_SWAP) || (op_q == OP_MOVE)));

    always_comb begin
        w_c  = host.cmd_sel ? cnt1_q : cnt0_q;
        w_o  = host.cmd_sel ? cnt0_q : cnt1_q;
        w_ok = 1'b0;
        case (host.cmd_op)
            OP_NOP:          w_ok = 1'b1;
            OP_PUSH:         w_ok = (w_c < c_WORDS);
            OP_POP, OP_PEEK: w_ok = (w_c >= c_ONE);
            OP_DUP:          w_ok = (w_c >= c_ONE) && (w_c < c_WORDS);
            OP_SWAP:         w_ok = (w_c >= c_TWO);
            OP_MOVE:         w_ok = (w_c >= c_ONE) && (w_o < c_WORDS);
            default:         w_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sel_d   = sel_q;
        ssel_d  = ssel_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        case (state_q)
            S_IDLE: begin
                if (host.cmd_valid && w_ready) begin
                    op_d   = host.cmd_op;
                    sel_d  = host.cmd_sel;
                    ssel_d = host.cmd_sel;
                    a_d    = host.cmd_data;
                    b_d    = 8'h00;
                    err_d  = !w_ok;
                    if (!w_ok || (host.cmd_op == OP_NOP)) state_d = S_RSP;
                    else if (host.cmd_op == OP_PUSH)      state_d = S_PUSHA;
                    else                                  state_d = S_WAIT;
                end
            end
            S_WAIT:  state_d = S_READA;
            S_READA: begin
                a_d = stk_data;
                case (op_q)
                    OP_DUP:  state_d = S_PUSHA;
                    OP_SWAP: state_d = S_READB;
                    OP_MOVE: begin
                        state_d = S_PUSHA;
                        ssel_d  = ~sel_q;
                    end
                    default: state_d = S_RSP;
                endcase
            end
            S_READB: begin
                b_d     = stk_data;
                state_d = S_PUSHA;
            end
            S_PUSHA: state_d = (op_q == OP_SWAP) ? S_PUSHB : S_RSP;
            S_PUSHB: state_d = S_RSP;
            S_RSP:   if (host.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes always target the stack currently selected, so mirror it there.
        if (w_push) begin
            if (ssel_q) cnt1_d = cnt1_q + c_ONE;
            else        cnt0_d = cnt0_q + c_ONE;
        end else if (w_pop) begin
            if (ssel_q) cnt1_d = cnt1_q - c_ONE;
            else        cnt0_d = cnt0_q - c_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            sel_q   <= 1'b0;
            ssel_q  <= 1'b0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            err_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            ssel_q  <= ssel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    always_comb begin
        w_rsp_data = 8'h00;
        if ((state_q == S_RSP) && !err_q) begin
            case (op_q)
                OP_NOP:  w_rsp_data = 8'h00;
                OP_SWAP: w_rsp_data = b_q;
                default: w_rsp_data = a_q;
            endcase
        end
    end

    assign host.cmd_ready = w_ready;
    assign host.rsp_valid = (state_q == S_RSP);
    assign host.rsp_err   = (state_q == S_RSP) && err_q;
    assign host.rsp_data  = w_rsp_data;
    assign stack_select   = ssel_q;
    assign push           = w_push;
    assign pop            = w_pop;
    assign data_in        = (state_q == S_PUSHA) ? a_q :
                            (state_q == S_PUSHB) ? b_q : 8'h00;
    assign count0         = cnt0_q;
    assign count1         = cnt1_q;

endmodule

`default_nettype wire
